// File: rtl/display_point_scheduler.sv
// rtl/display_point_scheduler.sv - two-source point arbiter, shared FIFO and paced strobe issue (optional FRAME_POINT_COUNT_EN)

module display_point_fifo #(
    parameter int WIDTH = 20,
    parameter int AW    = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic [AW:0]      level_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int          DEPTH   = 1 << AW;
    localparam logic [AW:0] DEPTH_L = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      level;
    logic             do_push;
    logic             do_pop;

    // A flush cycle swallows any push or pop so the queue ends up truly empty
    always_comb begin
        full_o  = (level == DEPTH_L);
        empty_o = (level == '0);
        do_push = push_i && !full_o && !flush_i;
        do_pop  = pop_i && !empty_o && !flush_i;
        rdata_o = mem[rd_ptr];
        level_o = level;
    end

    // Storage array; contents need no reset because level guards every read
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata_i;
        end
    end

    // Pointers wrap naturally at the depth; occupancy is tracked separately
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end
endmodule

module display_point_scheduler #(
    parameter int X_WIDTH = 10,
    parameter int Y_WIDTH = 10,
    parameter int FIFO_AW = 4,
    parameter int MIN_GAP = 3
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               req0_valid_i,
    output logic               req0_ready_o,
    input  logic [X_WIDTH-1:0] req0_x_i,
    input  logic [Y_WIDTH-1:0] req0_y_i,
    input  logic               req1_valid_i,
    output logic               req1_ready_o,
    input  logic [X_WIDTH-1:0] req1_x_i,
    input  logic [Y_WIDTH-1:0] req1_y_i,
    input  logic               newline_i,
    input  logic               flush_i,
    output logic               strobe_o,
    output logic [X_WIDTH-1:0] x_o,
    output logic [Y_WIDTH-1:0] y_o,
    output logic [FIFO_AW:0]   level_o
`ifdef FRAME_POINT_COUNT_EN
    ,
    input  logic               newframe_i,
    output logic [15:0]        points_o
`endif
);
    localparam int PW    = X_WIDTH + Y_WIDTH;
    localparam int GAP_W = $clog2(MIN_GAP + 2);

    typedef enum logic [0:0] {
        ST_IDLE,
        ST_GAP
    } issue_state_t;

    issue_state_t     state;
    logic [GAP_W-1:0] gap_cnt;
    logic             last_grant;
    logic             gnt0;
    logic             gnt1;
    logic             can_accept;
    logic             push;
    logic [PW-1:0]    push_data;
    logic             pop;
    logic [PW-1:0]    head;
    logic             fifo_full;
    logic             fifo_empty;

    // Round-robin: on a tie the requester that did not win last time is served
    always_comb begin
        can_accept = !fifo_full && !flush_i;
        gnt0       = can_accept && req0_valid_i && (!req1_valid_i || last_grant);
        gnt1       = can_accept && req1_valid_i && (!req0_valid_i || !last_grant);
        push       = gnt0 || gnt1;
        push_data  = gnt1 ? {req1_y_i, req1_x_i} : {req0_y_i, req0_x_i};
        pop        = (state == ST_IDLE) && !fifo_empty && !newline_i && !flush_i;
    end

    assign req0_ready_o = gnt0;
    assign req1_ready_o = gnt1;

    // Remember the last winner; reset value lets requester 0 take the first tie
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            last_grant <= 1'b1;
        end else if (gnt0) begin
            last_grant <= 1'b0;
        end else if (gnt1) begin
            last_grant <= 1'b1;
        end
    end

    display_point_fifo #(
        .WIDTH (PW),
        .AW    (FIFO_AW)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (flush_i),
        .push_i  (push),
        .wdata_i (push_data),
        .pop_i   (pop),
        .rdata_o (head),
        .level_o (level_o),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Issue FSM: pop the head into the output register, then sit out MIN_GAP cycles
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= ST_IDLE;
            gap_cnt  <= '0;
            strobe_o <= 1'b0;
            x_o      <= '0;
            y_o      <= '0;
        end else begin
            strobe_o <= pop;
            case (state)
                ST_IDLE: begin
                    if (pop) begin
                        x_o <= head[X_WIDTH-1:0];
                        y_o <= head[PW-1:X_WIDTH];
                        if (MIN_GAP != 0) begin
                            state   <= ST_GAP;
                            gap_cnt <= GAP_W'(MIN_GAP);
                        end
                    end
                end
                ST_GAP: begin
                    if (gap_cnt <= GAP_W'(1)) begin
                        state   <= ST_IDLE;
                        gap_cnt <= '0;
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    gap_cnt <= '0;
                end
            endcase
        end
    end

`ifdef FRAME_POINT_COUNT_EN
    logic [15:0] frame_cnt;
    logic [15:0] frame_cnt_next;

    // Saturating count that already includes a strobe in the current cycle
    always_comb begin
        frame_cnt_next = frame_cnt;
        if (strobe_o && (frame_cnt != 16'hFFFF)) begin
            frame_cnt_next = frame_cnt + 16'd1;
        end
    end

    // Snapshot the per-frame total on newframe_i and restart counting
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            frame_cnt <= '0;
            points_o  <= '0;
        end else if (newframe_i) begin
            points_o  <= frame_cnt_next;
            frame_cnt <= '0;
        end else begin
            frame_cnt <= frame_cnt_next;
        end
    end
`endif
endmodule

// File: tb/tb_display_point_scheduler.sv
// tb/tb_display_point_scheduler.sv - directed self-checking bench for display_point_scheduler

module tb_display_point_scheduler;
    logic       clk = 1'b0;
    logic       rst_i;
    logic       req0_valid_i;
    logic       req0_ready_o;
    logic [9:0] req0_x_i;
    logic [9:0] req0_y_i;
    logic       req1_valid_i;
    logic       req1_ready_o;
    logic [9:0] req1_x_i;
    logic [9:0] req1_y_i;
    logic       newline_i;
    logic       flush_i;
    logic       strobe_o;
    logic [9:0] x_o;
    logic [9:0] y_o;
    logic [4:0] level_o;
`ifdef FRAME_POINT_COUNT_EN
    logic        newframe_i = 1'b0;
    logic [15:0] points_o;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int base    = 0;
    logic [9:0] log_x [$];
    logic [9:0] log_y [$];
    int         log_c [$];

    display_point_scheduler dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .req0_valid_i (req0_valid_i),
        .req0_ready_o (req0_ready_o),
        .req0_x_i     (req0_x_i),
        .req0_y_i     (req0_y_i),
        .req1_valid_i (req1_valid_i),
        .req1_ready_o (req1_ready_o),
        .req1_x_i     (req1_x_i),
        .req1_y_i     (req1_y_i),
        .newline_i    (newline_i),
        .flush_i      (flush_i),
        .strobe_o     (strobe_o),
        .x_o          (x_o),
        .y_o          (y_o),
        .level_o      (level_o)
`ifdef FRAME_POINT_COUNT_EN
        ,
        .newframe_i   (newframe_i),
        .points_o     (points_o)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (strobe_o === 1'b1) begin
            log_x.push_back(x_o);
            log_y.push_back(y_o);
            log_c.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req0_valid_i = 1'b0;
        req1_valid_i = 1'b0;
        req0_x_i = '0;
        req0_y_i = '0;
        req1_x_i = '0;
        req1_y_i = '0;
        newline_i = 1'b0;
        flush_i = 1'b0;
        rst_i = 1'b1;
        tick();
        tick();
        rst_i = 1'b0;
        base = log_x.size();
    endtask

    task automatic wait_strobes(input int n, input int budget);
        int k = 0;
        while ((log_x.size() - base) < n && k < budget) begin
            tick();
            k++;
        end
        check("strobe_count", 32'(log_x.size() - base), 32'(n));
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_x [8];
        exp_x = '{1, 101, 2, 102, 3, 103, 4, 104};

        // reset state
        do_reset();
        check("rst_strobe", 32'(strobe_o), 0);
        check("rst_x", 32'(x_o), 0);
        check("rst_y", 32'(y_o), 0);
        check("rst_level", 32'(level_o), 0);

        // single point latency
        req0_valid_i = 1'b1;
        req0_x_i = 10'd5;
        req0_y_i = 10'd7;
        #1;
        check("single_ready0", 32'(req0_ready_o), 1);
        check("single_ready1", 32'(req1_ready_o), 0);
        tick();
        req0_valid_i = 1'b0;
        check("single_level1", 32'(level_o), 1);
        check("single_nostrobe", 32'(strobe_o), 0);
        tick();
        check("single_strobe", 32'(strobe_o), 1);
        check("single_x", 32'(x_o), 5);
        check("single_y", 32'(y_o), 7);
        check("single_level0", 32'(level_o), 0);
        tick();
        check("single_onecycle", 32'(strobe_o), 0);
        check("single_hold_x", 32'(x_o), 5);

        // contention, alternating grants from reset
        do_reset();
        begin
            int i0 = 0;
            int i1 = 0;
            for (int k = 0; k < 8; k++) begin
                req0_valid_i = (i0 < 4);
                req1_valid_i = (i1 < 4);
                req0_x_i = 10'(1 + i0);
                req0_y_i = 10'(200 + i0);
                req1_x_i = 10'(101 + i1);
                req1_y_i = 10'(300 + i1);
                #1;
                check("arb_ready0", 32'(req0_ready_o), 32'(k % 2 == 0));
                check("arb_ready1", 32'(req1_ready_o), 32'(k % 2 == 1));
                if (req0_ready_o) i0++;
                if (req1_ready_o) i1++;
                tick();
            end
            req0_valid_i = 1'b0;
            req1_valid_i = 1'b0;
        end
        wait_strobes(8, 60);
        for (int i = 0; i < 8 && (base + i) < log_x.size(); i++) begin
            check("arb_order_x", 32'(log_x[base + i]), 32'(exp_x[i]));
            check("arb_order_y", 32'(log_y[base + i]), 32'(exp_x[i] > 100 ? exp_x[i] + 199 : exp_x[i] + 199));
            if (i > 0) check("arb_spacing", 32'(log_c[base + i] - log_c[base + i - 1]), 4);
        end

        // pacing: three queued points, strobes exactly MIN_GAP+1 apart
        do_reset();
        for (int i = 0; i < 3; i++) begin
            req0_valid_i = 1'b1;
            req0_x_i = 10'(11 + i);
            req0_y_i = 10'(i);
            tick();
        end
        req0_valid_i = 1'b0;
        wait_strobes(3, 30);
        if (log_x.size() - base >= 3) begin
            check("pace_gap1", 32'(log_c[base + 1] - log_c[base]), 4);
            check("pace_gap2", 32'(log_c[base + 2] - log_c[base + 1]), 4);
            check("pace_x2", 32'(log_x[base + 2]), 13);
        end

        // newline in the idle cycle delays the next strobe by one
        do_reset();
        for (int i = 0; i < 3; i++) begin
            req0_valid_i = 1'b1;
            req0_x_i = 10'(21 + i);
            req0_y_i = 10'(i);
            tick();
        end
        req0_valid_i = 1'b0;
        tick();
        tick();
        newline_i = 1'b1;
        tick();
        newline_i = 1'b0;
        check("nl_held", 32'(strobe_o), 0);
        tick();
        check("nl_strobe", 32'(strobe_o), 1);
        check("nl_x", 32'(x_o), 22);
        wait_strobes(3, 30);
        if (log_x.size() - base >= 3) begin
            check("nl_gap1", 32'(log_c[base + 1] - log_c[base]), 5);
            check("nl_gap2", 32'(log_c[base + 2] - log_c[base + 1]), 4);
        end

        // backpressure: fill to 16 with output blocked, then one pop admits one point
        do_reset();
        newline_i = 1'b1;
        for (int i = 0; i < 16; i++) begin
            req0_valid_i = 1'b1;
            req0_x_i = 10'(i);
            req0_y_i = 10'(500 + i);
            #1;
            if (i == 0 || i == 15) check("bp_fill_ready", 32'(req0_ready_o), 1);
            tick();
        end
        req0_x_i = 10'd16;
        req0_y_i = 10'd516;
        req1_valid_i = 1'b1;
        req1_x_i = 10'd900;
        #1;
        check("bp_full_level", 32'(level_o), 16);
        check("bp_full_ready0", 32'(req0_ready_o), 0);
        check("bp_full_ready1", 32'(req1_ready_o), 0);
        tick();
        check("bp_still_full", 32'(level_o), 16);
        req1_valid_i = 1'b0;
        newline_i = 1'b0;
        #1;
        check("bp_prepop_ready0", 32'(req0_ready_o), 0);
        tick();
        newline_i = 1'b1;
        check("bp_after_pop_level", 32'(level_o), 15);
        check("bp_after_pop_ready0", 32'(req0_ready_o), 1);
        tick();
        check("bp_refull_level", 32'(level_o), 16);
        check("bp_refull_ready0", 32'(req0_ready_o), 0);
        req0_valid_i = 1'b0;
        newline_i = 1'b0;
        wait_strobes(17, 90);
        for (int i = 0; i < 17 && (base + i) < log_x.size(); i++) begin
            check("bp_order", 32'(log_x[base + i]), 32'(i));
        end

        // flush with requester 1 waiting, output blocked by newline
        do_reset();
        newline_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            req0_valid_i = 1'b1;
            req0_x_i = 10'(30 + i);
            tick();
        end
        req0_valid_i = 1'b0;
        check("fl_level5", 32'(level_o), 5);
        flush_i = 1'b1;
        req1_valid_i = 1'b1;
        req1_x_i = 10'd99;
        newline_i = 1'b0;
        #1;
        check("fl_ready1", 32'(req1_ready_o), 0);
        tick();
        flush_i = 1'b0;
        req1_valid_i = 1'b0;
        check("fl_level0", 32'(level_o), 0);
        repeat (10) tick();
        check("fl_no_strobe", 32'(log_x.size() - base), 0);

        // reset while a strobe is out and another point is queued
        for (int i = 0; i < 2; i++) begin
            req0_valid_i = 1'b1;
            req0_x_i = 10'(40 + i);
            tick();
        end
        req0_valid_i = 1'b0;
        begin
            int k = 0;
            while (strobe_o !== 1'b1 && k < 10) begin
                tick();
                k++;
            end
            check("rr_saw_strobe", 32'(strobe_o), 1);
        end
        rst_i = 1'b1;
        #1;
        check("rr_strobe_async", 32'(strobe_o), 0);
        check("rr_level_async", 32'(level_o), 0);
        check("rr_x_async", 32'(x_o), 0);
        base = log_x.size();
        tick();
        rst_i = 1'b0;
        repeat (20) tick();
        check("rr_no_strobe", 32'(log_x.size() - base), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
